// File: rtl/md5_round_ctl_pkg.sv
// Shared definitions for the MD5 round sequencer: FSM states, shift constants and the T-constant lookup.
// The MD5_BLKCNT_EN build option lives in md5_round_ctl; nothing here depends on it.
package md5_round_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FN_F = 2'd0,
    FN_G = 2'd1,
    FN_H = 2'd2,
    FN_I = 2'd3
  } func_e;

  localparam logic [5:0] LAST_ROUND = 6'd63;

  localparam logic [4:0] S11 = 5'd7, S12 = 5'd12, S13 = 5'd17, S14 = 5'd22;
  localparam logic [4:0] S21 = 5'd5, S22 = 5'd9,  S23 = 5'd14, S24 = 5'd20;
  localparam logic [4:0] S31 = 5'd4, S32 = 5'd11, S33 = 5'd16, S34 = 5'd23;
  localparam logic [4:0] S41 = 5'd6, S42 = 5'd10, S43 = 5'd15, S44 = 5'd21;

  // T00..T63: floor(|sin(i+1)| * 2^32).
  localparam logic [31:0] T_TABLE [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  function automatic logic [31:0] tlut(input logic [5:0] idx);
    return T_TABLE[idx];
  endfunction

  // Message word index g; every term is taken mod 16, so only the low nibble of the round matters.
  function automatic logic [3:0] widx_of(input logic [5:0] r);
    logic [3:0] lo;
    logic [3:0] g;
    lo = r[3:0];
    g  = lo;
    case (r[5:4])
      2'd1:    g = lo * 4'd5 + 4'd1;
      2'd2:    g = lo * 4'd3 + 4'd5;
      2'd3:    g = lo * 4'd7;
      default: g = lo;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_slut.sv
// Shift-amount lookup: round function and round[1:0] select the left-rotate amount.
module md5_slut
  import md5_round_ctl_pkg::*;
(
  input  logic [1:0] func,
  input  logic [1:0] step,
  output logic [4:0] shift
);

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    shift = S11;
    case ({func, step})
      {FN_F, 2'd0}: shift = S11;
      {FN_F, 2'd1}: shift = S12;
      {FN_F, 2'd2}: shift = S13;
      {FN_F, 2'd3}: shift = S14;
      {FN_G, 2'd0}: shift = S21;
      {FN_G, 2'd1}: shift = S22;
      {FN_G, 2'd2}: shift = S23;
      {FN_G, 2'd3}: shift = S24;
      {FN_H, 2'd0}: shift = S31;
      {FN_H, 2'd1}: shift = S32;
      {FN_H, 2'd2}: shift = S33;
      {FN_H, 2'd3}: shift = S34;
      {FN_I, 2'd0}: shift = S41;
      {FN_I, 2'd1}: shift = S42;
      {FN_I, 2'd2}: shift = S43;
      {FN_I, 2'd3}: shift = S44;
      default:      shift = S11;
    endcase
  end

endmodule

// File: rtl/md5_round_ctl.sv
// MD5 round sequencer: steps rounds 0..63 per block and presents T, g, s and function over valid/ready.
// Define MD5_BLKCNT_EN to add the completed-block counter output blkcnt_o.
module md5_round_ctl
  import md5_round_ctl_pkg::*;
`ifdef MD5_BLKCNT_EN
#(
  parameter int BLKCNT_W = 32
)
`endif
(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [5:0]    round_o,
  output logic [31:0]   t_o,
  output logic [3:0]    widx_o,
  output logic [4:0]    shift_o,
  output logic [1:0]    func_o,
  output logic          busy_o,
`ifdef MD5_BLKCNT_EN
  output logic          done_o,
  output logic [BLKCNT_W-1:0] blkcnt_o
`else
  output logic          done_o
`endif
);

  state_e     state_q, state_d;
  logic       accept, last;
  logic       load;
  logic [5:0] next_round;
  logic [4:0] shift_next;
  logic       valid_d, busy_d, done_d;

  assign accept = valid_o & ready_i;
  assign last   = (round_o == LAST_ROUND);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i)        state_d = ST_RUN;
        ST_RUN:  if (accept && last) state_d = ST_DONE;
        ST_DONE:                     state_d = ST_IDLE;
        default:                     state_d = ST_IDLE;
      endcase
    end
  end

  // Next-round index and flag values, all captured by the output register below.
  always_comb begin
    valid_d    = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    load       = 1'b0;
    next_round = round_o;
    if (!abort_i) begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          load       = 1'b1;
          next_round = '0;
        end
        ST_RUN: if (accept && !last) begin
          load       = 1'b1;
          next_round = round_o + 6'd1;
        end
        default: ;
      endcase
    end
  end

  md5_slut u_slut (
    .func  (next_round[5:4]),
    .step  (next_round[1:0]),
    .shift (shift_next)
  );

  // Round index and its derived values load together, so they always describe the same round.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      round_o <= '0;
      t_o     <= '0;
      widx_o  <= '0;
      shift_o <= '0;
      func_o  <= '0;
    end else begin
      valid_o <= valid_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
      if (abort_i) begin
        round_o <= '0;
        t_o     <= '0;
        widx_o  <= '0;
        shift_o <= '0;
        func_o  <= '0;
      end else if (load) begin
        round_o <= next_round;
        t_o     <= tlut(next_round);
        widx_o  <= widx_of(next_round);
        shift_o <= shift_next;
        func_o  <= next_round[5:4];
      end
    end
  end

`ifdef MD5_BLKCNT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      blkcnt_o <= '0;
    else if (state_q == ST_RUN && state_d == ST_DONE)
      blkcnt_o <= blkcnt_o + BLKCNT_W'(1);
  end
`endif

endmodule
